// File: rtl/seq_det_pkg.sv
// Shared types for the 1101 sequence detector and its word scheduler.
package seq_det_pkg;

  typedef enum logic {
    SCH_IDLE,
    SCH_SHIFT
  } sched_state_t;

  typedef enum logic [2:0] {
    DET_IDLE,
    DET_S1,
    DET_S11,
    DET_S110,
    DET_S1101
  } det_state_t;

  localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/seq_det_scheduler_if.sv
// Host-side handshake, flush, match reporting and IRQ bundle for seq_det_scheduler.
interface seq_det_scheduler_if #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 8
);
  localparam int unsigned POS_W = $clog2(WORD_W);

  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;
  logic              flush;
  logic              busy;
  logic              match_pulse;
  logic [POS_W-1:0]  match_pos;
  logic [CNT_W-1:0]  match_cnt;
  logic [CNT_W-1:0]  thresh;
  logic              irq_clr;
  logic              irq;

  modport master (
    output in_valid, in_data, flush, thresh, irq_clr,
    input  in_ready, busy, match_pulse, match_pos, match_cnt, irq
  );

  modport slave (
    input  in_valid, in_data, flush, thresh, irq_clr,
    output in_ready, busy, match_pulse, match_pos, match_cnt, irq
  );

endinterface

// File: rtl/seq_det_core.sv
// Mealy 1101 detector, overlapping; advances only when en is high, clr returns it to idle.
module seq_det_core
  import seq_det_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  input  logic x,
  output logic y
);

  det_state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) state_q <= DET_IDLE;
    else       state_q <= state_d;
  end

  // After a hit the trailing 1 is reused, so S1101 behaves like S1.
  always_comb begin
    state_d = state_q;
    y       = 1'b0;
    if (en) begin
      case (state_q)
        DET_IDLE:          state_d = (x == PATTERN[3]) ? DET_S1 : DET_IDLE;
        DET_S1, DET_S1101: state_d = (x == PATTERN[2]) ? DET_S11 : DET_IDLE;
        DET_S11:           state_d = (x == PATTERN[1]) ? DET_S110 : DET_S11;
        DET_S110: begin
          y       = (x == PATTERN[0]);
          state_d = (x == PATTERN[0]) ? DET_S1101 : DET_IDLE;
        end
        default:           state_d = DET_IDLE;
      endcase
    end
    if (clr) state_d = DET_IDLE;
  end

endmodule

// File: rtl/seq_det_scheduler.sv
// Serialises accepted words MSB-first into seq_det_core and accounts matches.
// Optional threshold interrupt enabled by defining SEQ_DET_IRQ_EN.
module seq_det_scheduler
  import seq_det_pkg::*;
#(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input logic               clk,
  input logic               reset,
  seq_det_scheduler_if.slave bus
);

  localparam int unsigned       IDX_W    = $clog2(WORD_W);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  sched_state_t      state_q, state_d;
  logic [WORD_W-1:0] shreg_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  pos_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              pulse_q;
  logic              ready_c;
  logic              load_c;
  logic              bit_en_c;
  logic              core_y;
  logic              hit_c;

  always_ff @(posedge clk) begin
    if (reset) state_q <= SCH_IDLE;
    else       state_q <= state_d;
  end

  // Flush overrides the handshake; the last-bit cycle may reload for gapless streaming.
  always_comb begin
    state_d  = state_q;
    ready_c  = 1'b0;
    bit_en_c = 1'b0;
    load_c   = 1'b0;
    case (state_q)
      SCH_IDLE:  ready_c = 1'b1;
      SCH_SHIFT: begin
        bit_en_c = 1'b1;
        ready_c  = (idx_q == LAST_IDX);
        if (ready_c) state_d = SCH_IDLE;
      end
      default:   state_d = SCH_IDLE;
    endcase
    if (bus.flush) begin
      ready_c = 1'b0;
      state_d = SCH_IDLE;
    end
    load_c = ready_c && bus.in_valid;
    if (load_c) state_d = SCH_SHIFT;
  end

  seq_det_core u_core (
    .clk   (clk),
    .reset (reset),
    .en    (bit_en_c),
    .clr   (bus.flush),
    .x     (shreg_q[WORD_W-1]),
    .y     (core_y)
  );

  assign hit_c = core_y && !bus.flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      idx_q   <= '0;
      pos_q   <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      if (load_c) begin
        shreg_q <= bus.in_data;
        idx_q   <= '0;
      end else if (bit_en_c) begin
        shreg_q <= {shreg_q[WORD_W-2:0], 1'b0};
        idx_q   <= idx_q + IDX_W'(1);
      end
      pulse_q <= hit_c;
      if (hit_c) pos_q <= idx_q;
      if (hit_c && (cnt_q != CNT_MAX)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef SEQ_DET_IRQ_EN
  logic irq_q;
  logic irq_set_c;

  // Set only on the increment that lands on thresh; set beats clear.
  assign irq_set_c = hit_c && (cnt_q != CNT_MAX) && (bus.thresh != '0) &&
                     ((cnt_q + CNT_W'(1)) == bus.thresh);

  always_ff @(posedge clk) begin
    if (reset)            irq_q <= 1'b0;
    else if (irq_set_c)   irq_q <= 1'b1;
    else if (bus.irq_clr) irq_q <= 1'b0;
  end

  assign bus.irq = irq_q;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{bus.thresh, bus.irq_clr};
  assign bus.irq = 1'b0;
`endif

  assign bus.in_ready    = ready_c;
  assign bus.busy        = (state_q == SCH_SHIFT);
  assign bus.match_pulse = pulse_q;
  assign bus.match_pos   = pos_q;
  assign bus.match_cnt   = cnt_q;

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed bench for seq_det_scheduler; IRQ expectations follow SEQ_DET_IRQ_EN.
module tb_seq_det_scheduler;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  int   n_pulse = 0;
  int   pos_log [512];
  int   cyc_log [512];
  bit   irq_log [512];

  seq_det_scheduler_if #(.WORD_W(8), .CNT_W(8)) bus ();

  seq_det_scheduler #(.WORD_W(8), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.match_pulse && n_pulse < 512) begin
      pos_log[n_pulse] <= 32'(bus.match_pos);
      cyc_log[n_pulse] <= cyc;
      irq_log[n_pulse] <= bus.irq;
      n_pulse          <= n_pulse + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".in_ready"}, 32'(bus.in_ready), 1);
    check({tag, ".busy"},     32'(bus.busy), 0);
    check({tag, ".pulse"},    32'(bus.match_pulse), 0);
    check({tag, ".pos"},      32'(bus.match_pos), 0);
    check({tag, ".cnt"},      32'(bus.match_cnt), 0);
    check({tag, ".irq"},      32'(bus.irq), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
  endtask

  // Offer a word at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [7:0] data, output int acc);
    int tmo = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    while (!bus.in_ready && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 50) check("send_timeout", 32'(tmo), 0);
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    bus.in_valid = 1'b0;
  endtask

  int acc, acc2, base;
  bit irq_on;

  initial begin
`ifdef SEQ_DET_IRQ_EN
    irq_on = 1'b1;
`else
    irq_on = 1'b0;
`endif
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.flush    = 1'b0;
    bus.thresh   = '0;
    bus.irq_clr  = 1'b0;
    reset = 1'b1;
    wait_cycles(2);
    check_reset_values("reset");
    reset = 1'b0;

    // Single match, latency from accept edge
    base = n_pulse;
    send(8'b1101_0000, acc);
    wait_cycles(12);
    check("t1.npulse",  32'(n_pulse - base), 1);
    check("t1.pos",     32'(pos_log[base]), 3);
    check("t1.latency", 32'(cyc_log[base] - acc), 4);
    check("t1.cnt",     32'(bus.match_cnt), 1);
    check("t1.idle",    32'(bus.busy), 0);

    // Overlapping matches inside one word
    do_reset();
    base = n_pulse;
    send(8'b1101_1010, acc);
    wait_cycles(12);
    check("t2.npulse", 32'(n_pulse - base), 2);
    check("t2.pos0",   32'(pos_log[base]), 3);
    check("t2.pos1",   32'(pos_log[base + 1]), 6);
    check("t2.cnt",    32'(bus.match_cnt), 2);

    // Back-to-back words; match spans the boundary
    do_reset();
    base = n_pulse;
    send(8'b0000_0110, acc);
    send(8'b1000_0000, acc2);
    check("t3.gapless", 32'(acc2 - acc), 8);
    check("t3.busy",    32'(bus.busy), 1);
    wait_cycles(12);
    check("t3.npulse",  32'(n_pulse - base), 1);
    check("t3.pos",     32'(pos_log[base]), 0);
    check("t3.latency", 32'(cyc_log[base] - acc2), 1);
    check("t3.cnt",     32'(bus.match_cnt), 1);

    // Same words with a flush in between; a word offered with flush is refused
    do_reset();
    base = n_pulse;
    send(8'b0000_0110, acc);
    wait_cycles(9);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'b1000_0000;
    #1;
    check("t3f.ready_during_flush", 32'(bus.in_ready), 0);
    @(negedge clk);
    check("t3f.not_accepted", 32'(bus.busy), 0);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    send(8'b1000_0000, acc);
    wait_cycles(12);
    check("t3f.npulse", 32'(n_pulse - base), 0);
    check("t3f.cnt",    32'(bus.match_cnt), 0);

    // Flush in the cycle the completing bit is presented suppresses the match
    do_reset();
    base = n_pulse;
    send(8'b1101_0000, acc);
    wait_cycles(3);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("tfl.pulse", 32'(bus.match_pulse), 0);
    check("tfl.busy",  32'(bus.busy), 0);
    wait_cycles(10);
    check("tfl.npulse", 32'(n_pulse - base), 0);
    check("tfl.cnt",    32'(bus.match_cnt), 0);

    // Saturation: 2 matches per word
    do_reset();
    base = n_pulse;
    for (int w = 0; w < 127; w++) send(8'b1101_1010, acc);
    wait_cycles(12);
    check("t4.cnt254", 32'(bus.match_cnt), 254);
    for (int w = 0; w < 23; w++) send(8'b1101_1010, acc);
    wait_cycles(12);
    check("t4.npulse", 32'(n_pulse - base), 300);
    check("t4.cnt255", 32'(bus.match_cnt), 255);

    // Threshold interrupt, then irq_clr held across a 4th match
    do_reset();
    bus.thresh = 8'd3;
    base = n_pulse;
    send(8'b1101_1010, acc);
    send(8'b1101_0000, acc);
    wait_cycles(12);
    check("t5.npulse",    32'(n_pulse - base), 3);
    check("t5.irq_at2",   32'(irq_log[base + 1]), 0);
    check("t5.irq_at3",   32'(irq_log[base + 2]), 32'(irq_on));
    check("t5.irq_stick", 32'(bus.irq), 32'(irq_on));
    bus.irq_clr = 1'b1;
    send(8'b1101_0000, acc);
    wait_cycles(12);
    check("t5.irq_at4",   32'(irq_log[base + 3]), 0);
    check("t5.irq_clr",   32'(bus.irq), 0);
    check("t5.cnt",       32'(bus.match_cnt), 4);
    bus.irq_clr = 1'b0;
    bus.thresh  = '0;

    // Mid-word reset at bit 4, then no spurious match
    send(8'b1111_1101, acc);
    wait_cycles(4);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("t6");
    reset = 1'b0;
    base = n_pulse;
    send(8'b0000_0001, acc);
    wait_cycles(12);
    check("t6.npulse", 32'(n_pulse - base), 0);
    check("t6.cnt",    32'(bus.match_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
